mosfet_loader: RTL
==================

MOSFET_LOADER -- requirements
Module: mosfet_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port in_valid, input, 1 bit: a transistor beat is presented this cycle.
REQ-005 Port in_ready, output, 1 bit: the block accepts a beat this cycle; a beat is accepted when in_valid && in_ready.
REQ-006 Port mode, input, 2 bits: packet mode, sampled on beat 0 only.
REQ-007 Port W, input, 3 bits: transistor width, legal range 1..7.
REQ-008 Port V_GS, input, 3 bits: gate-source voltage.
REQ-009 Port V_DS, input, 3 bits: drain-source voltage.
REQ-010 Port out_valid, output, 1 bit: a packet bundle is presented downstream.
REQ-011 Port out_ready, input, 1 bit: the downstream sort/sum stage accepts the bundle.
REQ-012 Port out_mode, output, 2 bits: the mode latched from beat 0.
REQ-013 Port out_id, output, 42 bits: six 7-bit ID lanes; lane k occupies bits [7k+6:7k] and holds beat k.
REQ-014 Port out_gm, output, 30 bits: six 5-bit gm lanes; lane k occupies bits [5k+4:5k].

Function
REQ-015 The state machine SHALL have states IDLE, LOAD and HOLD.
REQ-016 Transitions: IDLE->LOAD on an accepted beat 0; LOAD->HOLD on an accepted beat 5; HOLD->IDLE when out_valid && out_ready.
REQ-017 in_ready SHALL be 1 in IDLE and LOAD, and 0 in HOLD; it is combinational from state only.
REQ-018 A 3-bit beat counter (0..5) SHALL increment per accepted beat and clear on reaching 5.
REQ-019 Per beat, the block SHALL compute Vov = V_GS-1, floored at 0; V_GS = 0 or 1 gives ID = 0 and gm = 0.
REQ-020 Triode region applies when Vov > V_DS: ID = W*V_DS*(2*Vov-V_DS)/3 and gm = 2*W*V_DS/3.
REQ-021 Saturation applies otherwise: ID = W*Vov*Vov/3 and gm = 2*W*Vov/3.
REQ-022 All divisions SHALL truncate; internal products SHALL be at least 9 bits; results SHALL fit 7 bits (max 84) and 5 bits (max 28).
REQ-023 Results SHALL be registered into lane k in the cycle beat k is accepted.
REQ-024 out_valid SHALL rise in the cycle after beat 5 is accepted (1-cycle latency) and stay high, with out_id, out_gm and out_mode stable, until out_ready.
REQ-025 Lanes SHALL hold their values after handshake until overwritten by a new beat.
REQ-026 Gaps in in_valid during LOAD SHALL stall: the counter holds and the partial lanes are kept.
REQ-027 out_ready while out_valid = 0 SHALL be ignored.
REQ-028 in_valid during HOLD SHALL be ignored (not accepted).
REQ-029 The cycle after the handshake is IDLE, so a new beat 0 can be accepted then; throughput is one packet per 7 cycles.

Reset
REQ-030 When rst = 1 at a clock edge: state = IDLE, counter = 0, out_valid = 0, out_mode = 0, out_id = 0, out_gm = 0.
REQ-031 Reset SHALL take priority over any beat or handshake in the same cycle.
REQ-032 Reset in LOAD or HOLD SHALL discard the packet; in_ready = 1 in the cycle following reset.

Configuration
REQ-033 Macro MOSFET_LOADER_ABORT_EN: when defined, in_valid = 0 for any cycle in LOAD SHALL clear the counter, zero all lanes and return to IDLE (partial packet dropped, no out_valid).
REQ-034 When MOSFET_LOADER_ABORT_EN is undefined, REQ-026 stall behaviour applies.

Verification
REQ-035 Six back-to-back beats, mode=2'b11, each W=3,V_GS=5,V_DS=2 -> triode; every lane ID=12, gm=4; out_valid on cycle 7; out_mode=3.
REQ-036 Beats all W=7,V_GS=7,V_DS=7 -> saturation; every lane ID=84, gm=28; check no overflow.
REQ-037 Beat W=1,V_GS=2,V_DS=1, and beat V_GS=0 -> that lane ID=0, gm=0.
REQ-038 out_ready held 0 for 10 cycles after out_valid -> bundle stable, in_ready=0, in_valid beats ignored; out_ready=1 -> IDLE next cycle, and beat 0 is accepted that cycle.
REQ-039 3-cycle in_valid gap after beat 2: without macro, packet completes with correct lanes; with MOSFET_LOADER_ABORT_EN, no out_valid, and the next 6 beats form a fresh packet.
REQ-040 rst=1 asserted in HOLD -> next cycle out_valid=0, all lanes 0, in_ready=1.

Source files
------------

// File: rtl/mosfet_loader.sv
// Six-beat MOSFET packet loader: computes square-law ID/gm per beat into lanes and
// hands the bundle downstream. Define MOSFET_LOADER_ABORT_EN to drop partial packets on an in_valid gap.
module mosfet_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  mode,
  input  logic [2:0]  W,
  input  logic [2:0]  V_GS,
  input  logic [2:0]  V_DS,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_mode,
  output logic [41:0] out_id,
  output logic [29:0] out_gm
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [41:0] id_q, id_d;
  logic [29:0] gm_q, gm_d;

  logic        accept;
  logic [2:0]  vov;
  logic [3:0]  span;
  logic [9:0]  id_prod, gm_prod;
  logic [6:0]  id_calc;
  logic [4:0]  gm_calc;

  // Device model: both regions share the W*x*y/3 form, so only the factors are muxed.
  always_comb begin
    vov = (V_GS > 3'd1) ? V_GS - 3'd1 : 3'd0;
    span = 4'd0;
    if (vov > V_DS) begin
      span    = {vov, 1'b0} - {1'b0, V_DS};
      id_prod = 10'(W) * 10'(V_DS) * 10'(span);
      gm_prod = 10'(W) * 10'(V_DS) * 10'd2;
    end else begin
      id_prod = 10'(W) * 10'(vov) * 10'(vov);
      gm_prod = 10'(W) * 10'(vov) * 10'd2;
    end
    id_calc = 7'(id_prod / 10'd3);
    gm_calc = 5'(gm_prod / 10'd3);
  end

  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign out_mode  = mode_q;
  assign out_id    = id_q;
  assign out_gm    = gm_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    id_d    = id_q;
    gm_d    = gm_q;

    if (accept) begin
      cnt_d = (cnt_q == 3'd5) ? 3'd0 : cnt_q + 3'd1;
      if (cnt_q == 3'd0) mode_d = mode;
      for (int k = 0; k < 6; k++) begin
        if (cnt_q == 3'(k)) begin
          id_d[7*k +: 7] = id_calc;
          gm_d[5*k +: 5] = gm_calc;
        end
      end
    end

    case (state_q)
      IDLE: if (accept) state_d = LOAD;
      LOAD: begin
        if (accept && cnt_q == 3'd5) state_d = HOLD;
`ifdef MOSFET_LOADER_ABORT_EN
        else if (!in_valid) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          id_d    = '0;
          gm_d    = '0;
        end
`endif
      end
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      mode_q  <= 2'd0;
      id_q    <= '0;
      gm_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      id_q    <= id_d;
      gm_q    <= gm_d;
    end
  end

endmodule
